// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 13:1 mux scan sequencer.
package mux_scan_pkg;

   localparam int NCH_DEF  = 13;
   localparam int SELW_DEF = 4;
   // Settle counter width; covers settle times up to 15 cycles.
   localparam int CNTW     = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DONE
   } state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Priority encoder over the channel mask: next enabled channel above the
// current select, whether one exists, and the lowest enabled channel.
module mux_scan_next_ch
   import mux_scan_pkg::*;
#(
   parameter int NCH  = NCH_DEF,
   parameter int SELW = SELW_DEF
) (
   input  logic [NCH-1:0]  i_mask,
   input  logic [SELW-1:0] i_cur,
   output logic [SELW-1:0] o_next,
   output logic            o_has_next,
   output logic [SELW-1:0] o_low
);

   logic [NCH-1:0] w_above;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_above
         assign w_above[gi] = i_mask[gi] && (SELW'(gi) > i_cur);
      end
   endgenerate

   assign o_has_next = |w_above;

   // Descending sweep so the last hit is the lowest qualifying index.
   always_comb begin
      o_next = '0;
      o_low  = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (w_above[k]) o_next = SELW'(k);
         if (i_mask[k])  o_low  = SELW'(k);
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Mux scan sequencer: steps the select through enabled channels, samples the
// mux output after a settle time and hands the frame off over valid/ready.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int NCH        = NCH_DEF,
   parameter int SELW       = SELW_DEF,
   parameter int SETTLE_CYC = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            cont,
   input  logic [NCH-1:0]  mask,
   output logic [SELW-1:0] s,
   input  logic            o,
   output logic [NCH-1:0]  frame,
   output logic            frame_valid,
   input  logic            frame_ready,
   output logic            busy
);

   state_t            r_state, w_state_next;
   logic [SELW-1:0]   r_s, w_s_next;
   logic [CNTW-1:0]   r_cnt, w_cnt_next;
   logic [NCH-1:0]    r_acc, w_acc_next;
   logic [NCH-1:0]    r_frame, w_frame_next;
   logic              r_valid, w_valid_next;
   logic [NCH-1:0]    r_mask, w_mask_next;
   logic              r_cont, w_cont_next;

   logic [NCH-1:0]    w_enc_mask;
   logic [NCH-1:0]    w_acc_sampled;
   logic [SELW-1:0]   w_next_ch;
   logic [SELW-1:0]   w_low_ch;
   logic              w_has_next;
   logic              w_last_cyc;

   // In IDLE the lowest channel must come from the live mask being latched.
   assign w_enc_mask = (r_state == IDLE) ? mask : r_mask;

   mux_scan_next_ch #(
      .NCH  (NCH),
      .SELW (SELW)
   ) u_next_ch (
      .i_mask     (w_enc_mask),
      .i_cur      (r_s),
      .o_next     (w_next_ch),
      .o_has_next (w_has_next),
      .o_low      (w_low_ch)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_sample
         assign w_acc_sampled[gi] = (r_s == SELW'(gi)) ? o : r_acc[gi];
      end
   endgenerate

   assign w_last_cyc = (r_cnt == CNTW'(SETTLE_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_s     <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_frame <= '0;
         r_valid <= 1'b0;
         r_mask  <= '0;
         r_cont  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_s     <= w_s_next;
         r_cnt   <= w_cnt_next;
         r_acc   <= w_acc_next;
         r_frame <= w_frame_next;
         r_valid <= w_valid_next;
         r_mask  <= w_mask_next;
         r_cont  <= w_cont_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_s_next     = r_s;
      w_cnt_next   = r_cnt;
      w_acc_next   = r_acc;
      w_frame_next = r_frame;
      w_valid_next = r_valid;
      w_mask_next  = r_mask;
      w_cont_next  = r_cont;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_mask_next = mask;
               w_cont_next = cont;
               w_acc_next  = '0;
               w_cnt_next  = '0;
               if (|mask) begin
                  w_state_next = SETTLE;
                  w_s_next     = w_low_ch;
               end else begin
                  w_state_next = DONE;
                  w_frame_next = '0;
                  w_valid_next = 1'b1;
               end
            end
         end
         SETTLE: begin
            if (w_last_cyc) begin
               w_acc_next = w_acc_sampled;
               w_cnt_next = '0;
               if (w_has_next) begin
                  w_s_next = w_next_ch;
               end else begin
                  w_state_next = DONE;
                  w_frame_next = w_acc_sampled;
                  w_valid_next = 1'b1;
               end
            end else begin
               w_cnt_next = r_cnt + CNTW'(1);
            end
         end
         DONE: begin
            if (frame_ready) begin
               w_valid_next = 1'b0;
               w_acc_next   = '0;
               w_cnt_next   = '0;
               // An empty mask has nothing to re-scan, so continuous mode ends.
               if (r_cont && (|r_mask)) begin
                  w_state_next = SETTLE;
                  w_s_next     = w_low_ch;
               end else begin
                  w_state_next = IDLE;
                  w_s_next     = '0;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
            w_s_next     = '0;
         end
      endcase
   end

   assign s           = r_s;
   assign frame       = r_frame;
   assign frame_valid = r_valid;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a mux model feeds o from a pattern indexed
// by the select, and every step compares outputs against hand-derived values.
module tb_mux_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        cont;
   logic [12:0] mask;
   logic [3:0]  s;
   logic        o;
   logic [12:0] frame;
   logic        frame_valid;
   logic        frame_ready;
   logic        busy;

   logic [12:0] mux_in;
   logic [15:0] mux_ext;
   logic        glitch_en;
   logic [3:0]  s_d;
   logic        busy_d;
   logic        first_cyc;

   int n_checks = 0;
   int n_err    = 0;

   mux_scan_ctrl #(
      .NCH        (13),
      .SELW       (4),
      .SETTLE_CYC (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .cont        (cont),
      .mask        (mask),
      .s           (s),
      .o           (o),
      .frame       (frame),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // The first cycle of each channel is where s has just moved (or busy just rose).
   always @(posedge clk) begin
      s_d    <= s;
      busy_d <= busy;
   end
   assign first_cyc = busy & (~busy_d | (s != s_d));
   assign mux_ext   = {3'b000, mux_in};
   assign o         = mux_ext[s] ^ (glitch_en & first_cyc);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [12:0] m, input logic c);
      mask  = m;
      cont  = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mask  = 13'h1555;
      cont  = ~c;
   endtask

   // Entered at the first cycle after start/handshake; returns on the valid cycle.
   task automatic scan_check(input string tag, input logic [12:0] m, input logic [12:0] exp_frame);
      for (int k = 0; k < 13; k++) begin
         if (m[k]) begin
            for (int c = 0; c < 2; c++) begin
               chk({tag, "_s"}, 32'(s), 32'(k));
               chk({tag, "_valid_low"}, 32'(frame_valid), 32'd0);
               chk({tag, "_busy"}, 32'(busy), 32'd1);
               @(negedge clk);
            end
         end
      end
      chk({tag, "_valid"}, 32'(frame_valid), 32'd1);
      chk({tag, "_frame"}, 32'(frame), 32'(exp_frame));
      chk({tag, "_busy_done"}, 32'(busy), 32'd1);
      $display("frame %s: mask=%h frame=%h valid=%0d", tag, m, frame, frame_valid);
   endtask

   task automatic hs(input string tag);
      frame_ready = 1'b1;
      @(negedge clk);
      frame_ready = 1'b0;
      chk({tag, "_hs_valid"}, 32'(frame_valid), 32'd0);
      chk({tag, "_hs_busy"}, 32'(busy), 32'd0);
      chk({tag, "_hs_s"}, 32'(s), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      rst_n       = 1'b0;
      start       = 1'b0;
      cont        = 1'b0;
      mask        = '0;
      frame_ready = 1'b0;
      glitch_en   = 1'b0;
      mux_in      = 13'b1010011101110;

      repeat (3) @(negedge clk);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_frame", 32'(frame), 32'd0);
      chk("rst_valid", 32'(frame_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // Full scan, then backpressure with start pulses that must be ignored.
      do_start(13'h1FFF, 1'b0);
      scan_check("full", 13'h1FFF, 13'h14EE);
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         mask  = 13'h0001;
         @(negedge clk);
         chk("bp_valid", 32'(frame_valid), 32'd1);
         chk("bp_frame", 32'(frame), 32'h14EE);
         chk("bp_busy", 32'(busy), 32'd1);
      end
      start = 1'b0;
      hs("full");
      chk("full_frame_held", 32'(frame), 32'h14EE);
      @(negedge clk);
      chk("full_no_restart", 32'(busy), 32'd0);

      // Channels 1, 4, 11; only bit 1 of the pattern is set among them.
      do_start(13'h0812, 1'b0);
      scan_check("sparse", 13'h0812, 13'h0002);
      hs("sparse");
      chk("sparse_frame_held", 32'(frame), 32'h0002);

      do_start(13'h0000, 1'b0);
      scan_check("empty", 13'h0000, 13'h0000);
      hs("empty");

      // Continuous mode over channels 1,2,4,6,11 with ready tied high.
      frame_ready = 1'b1;
      do_start(13'h0856, 1'b1);
      scan_check("cont1", 13'h0856, 13'h0046);
      mux_in = 13'h0A55;
      @(negedge clk);
      scan_check("cont2", 13'h0856, 13'h0854);
      mux_in = 13'b1010011101110;
      @(negedge clk);
      chk("cont3_s_low", 32'(s), 32'd1);
      chk("cont3_busy", 32'(busy), 32'd1);
      chk("cont3_valid", 32'(frame_valid), 32'd0);

      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (s == 4'd6) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("reach_s6", 32'(found), 32'd1);

      // Reset asserted between edges: outputs must clear without a clock.
      #2 rst_n = 1'b0;
      #1;
      chk("arst_s", 32'(s), 32'd0);
      chk("arst_frame", 32'(frame), 32'd0);
      chk("arst_valid", 32'(frame_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n       = 1'b1;
      frame_ready = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", 32'(frame_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      do_start(13'h1FFF, 1'b0);
      scan_check("refull", 13'h1FFF, 13'h14EE);
      hs("refull");

      // o toggles in each channel's first settle cycle only.
      glitch_en = 1'b1;
      mux_in    = 13'h0B3C;
      do_start(13'h1FFF, 1'b0);
      scan_check("glitch", 13'h1FFF, 13'h0B3C);
      hs("glitch");
      glitch_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
